l2_arbiter: RTL and testbench
=============================

# l2_arbiter

Two-port arbiter that shares the single unified L2 cache port between the L1 instruction cache and the L1 data cache. It sits between the two L1 miss/writeback interfaces and the L2 cache controller's CPU-side port. It grants one requester at a time with round-robin fairness and forwards that requester's read/write, address and write line to L2. It routes the L2 response and read line back to the granted requester only, and keeps saturating grant counters for performance monitoring.

## Interface
- ADDR_W, 16, byte address width (lc3b address)
- LINE_W, 128, cache line width in bits
- CNT_W, 16, width of each grant counter
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_read / i_write  in  1 / 1  I-cache request strobes, held until i_resp
- i_address  in  ADDR_W  I-cache line address
- i_wdata  in  LINE_W  I-cache write line (normally unused)
- i_resp  out  1  response to I-cache
- i_rdata  out  LINE_W  read line to I-cache
- d_read / d_write  in  1 / 1  D-cache request strobes, held until d_resp
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache write line
- d_resp  out  1  response to D-cache
- d_rdata  out  LINE_W  read line to D-cache
- l2_read / l2_write  out  1 / 1  request to L2 controller
- l2_address  out  ADDR_W  address to L2
- l2_wdata  out  LINE_W  write line to L2
- l2_resp  in  1  L2 response, single-cycle pulse per transaction
- l2_rdata  in  LINE_W  L2 read line, valid while l2_resp=1
- i_grant_cnt / d_grant_cnt  out  CNT_W  saturating count of grants issued

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D. State, rr_last and counters are registers. All other outputs are combinational from state and inputs.
- Request pending: i_req = i_read | i_write; d_req = d_read | d_write.
- IDLE
  - l2_read = l2_write = 0; l2_address and l2_wdata = 0.
  - Only d_req: next state GRANT_D. Only i_req: next state GRANT_I.
  - Both: grant the port not equal to rr_last.
  - Neither: stay in IDLE.
- GRANT_x
  - l2_read/l2_write/l2_address/l2_wdata = x's signals, unmodified (read and write both high is passed as-is).
  - x_rdata = l2_rdata; x_resp = l2_resp. The other port's resp = 0 and rdata = 0.
- On l2_resp in GRANT_x:
  - rr_last <= x.
  - If the other port's req is pending, go directly to GRANT_other (back-to-back handoff).
  - Otherwise go to IDLE.
- Without l2_resp, stay in GRANT_x regardless of the other port's requests. There is no preemption.
- Granted requester drops its strobes before l2_resp: stay in GRANT_x and forward zeros. This is a requester protocol violation; the arbiter does not recover from it.
- Counters
  - x_grant_cnt increments by 1 on each entry into GRANT_x, including handoff entries.
  - Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset (reset_n=0, asynchronous, effective immediately):
  - State = IDLE; rr_last = I, so D wins the first tie.
  - Both counters = 0; all l2_* outputs, i_resp, d_resp and rdata outputs = 0.
- Reset asserted mid-transaction aborts the grant immediately. The L2 request drops in the same cycle and no resp is forwarded.
- Arbitration latency: a request first seen in IDLE at edge N is presented to L2 from edge N+1 onward.
- Response path: l2_resp to x_resp is zero-cycle combinational.
- Handoff: the cycle after l2_resp, L2 sees the other port's request with no idle bubble.
- Throughput:
  - Handoff transactions: one per L2 service time.
  - A transaction that starts from IDLE costs one extra cycle.
- A request arriving in the same cycle the L2 responds to the other port is granted at the next edge.

## Test plan
- Reset: hold reset_n=0 with both requests high.
  - Required: all outputs 0, counters 0.
  - After release, first grant is D and d_grant_cnt=1.
- Single I read: i_read=1, i_address=16'h1230, L2 returns l2_rdata=128'hA5..A5 with l2_resp 3 cycles after grant.
  - Required: l2_read=1 from the cycle after the request with l2_address=16'h1230.
  - i_resp=1 with i_rdata=128'hA5..A5; d_resp stays 0.
  - State is IDLE the next cycle.
- Simultaneous requests: I read 16'h0040 and D write 16'h8000 with d_wdata=128'h0F..0F, both held.
  - Required: D served first with l2_write=1 and l2_wdata=128'h0F..0F.
  - On l2_resp, I is granted the next cycle with no IDLE bubble.
  - Both counters = 1.
- Fairness: both ports request continuously for 6 transactions.
  - Required: grants alternate D,I,D,I,D,I; counters 3/3.
- Async reset mid-grant: assert reset_n=0 while in GRANT_I before l2_resp.
  - Required: l2_read falls in the same cycle without waiting for clk; i_resp never pulses; state is IDLE.
- Saturation: with CNT_W=4, issue 20 D-only transactions.
  - Required: d_grant_cnt stops at 4'hF; i_grant_cnt=0.

Source files
------------

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the unified L2 cache port between the L1 I-cache and D-cache.
// One requester is granted at a time; the L2 response is routed back to it alone.
module l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata,
  output logic [CNT_W-1:0]  i_grant_cnt,
  output logic [CNT_W-1:0]  d_grant_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } state_t;

  localparam logic             RR_I    = 1'b0;
  localparam logic             RR_D    = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_nxt_s;
  logic             rr_last_r;
  logic             rr_last_nxt_s;
  logic             i_req_s;
  logic             d_req_s;
  logic             i_enter_s;
  logic             d_enter_s;
  logic [CNT_W-1:0] i_cnt_r;
  logic [CNT_W-1:0] d_cnt_r;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic enable);
    if (enable && (value != CNT_MAX)) begin
      return value + CNT_ONE;
    end else begin
      return value;
    end
  endfunction

  assign i_req_s = i_read | i_write;
  assign d_req_s = d_read | d_write;

  // State register and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      rr_last_r <= RR_I;
    end else begin
      state_r   <= state_nxt_s;
      rr_last_r <= rr_last_nxt_s;
    end
  end

  // Next-state and port steering; the granted port owns the L2 port until l2_resp
  always_comb begin
    state_nxt_s   = state_r;
    rr_last_nxt_s = rr_last_r;
    l2_read       = 1'b0;
    l2_write      = 1'b0;
    l2_address    = {ADDR_W{1'b0}};
    l2_wdata      = {LINE_W{1'b0}};
    i_resp        = 1'b0;
    i_rdata       = {LINE_W{1'b0}};
    d_resp        = 1'b0;
    d_rdata       = {LINE_W{1'b0}};
    case (state_r)
      IDLE: begin
        if (i_req_s && d_req_s) begin
          if (rr_last_r == RR_I) begin
            state_nxt_s = GRANT_D;
          end else begin
            state_nxt_s = GRANT_I;
          end
        end else if (d_req_s) begin
          state_nxt_s = GRANT_D;
        end else if (i_req_s) begin
          state_nxt_s = GRANT_I;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT_I: begin
        l2_read    = i_read;
        l2_write   = i_write;
        l2_address = i_address;
        l2_wdata   = i_wdata;
        i_resp     = l2_resp;
        i_rdata    = l2_rdata;
        if (l2_resp) begin
          rr_last_nxt_s = RR_I;
          if (d_req_s) begin
            state_nxt_s = GRANT_D;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = GRANT_I;
        end
      end
      GRANT_D: begin
        l2_read    = d_read;
        l2_write   = d_write;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        d_resp     = l2_resp;
        d_rdata    = l2_rdata;
        if (l2_resp) begin
          rr_last_nxt_s = RR_D;
          if (i_req_s) begin
            state_nxt_s = GRANT_I;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = GRANT_D;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // A grant is counted on entry, which includes back-to-back handoff entries
  assign i_enter_s = (state_nxt_s == GRANT_I) && (state_r != GRANT_I);
  assign d_enter_s = (state_nxt_s == GRANT_D) && (state_r != GRANT_D);

  // Saturating grant counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_cnt_r <= {CNT_W{1'b0}};
      d_cnt_r <= {CNT_W{1'b0}};
    end else begin
      i_cnt_r <= sat_inc(i_cnt_r, i_enter_s);
      d_cnt_r <= sat_inc(d_cnt_r, d_enter_s);
    end
  end

  assign i_grant_cnt = i_cnt_r;
  assign d_grant_cnt = d_cnt_r;

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed requester/L2 stimulus, a transaction-level model of
// ownership and grant counts, per-cycle comparison plus hand-computed literal checks.
module tb_l2_arbiter;

  localparam int CMAX = 15;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_read, i_write, i_resp, d_read, d_write, d_resp;
  logic [15:0]  i_address, d_address, l2_address;
  logic [127:0] i_wdata, d_wdata, i_rdata, d_rdata, l2_wdata, l2_rdata;
  logic         l2_read, l2_write, l2_resp;
  logic [3:0]   i_grant_cnt, d_grant_cnt;

  l2_arbiter #(.ADDR_W(16), .LINE_W(128), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  txn_t i_tab[64];
  txn_t d_tab[64];
  int   n_i = 0, n_d = 0, i_idx = 0, d_idx = 0;
  logic i_act = 1'b0, d_act = 1'b0, i_got = 1'b0, d_got = 1'b0;
  logic flush = 1'b0;
  int   lat = 2;
  int   rcnt = 0;
  int   resp_log[16];
  int   n_log = 0;
  logic i_pulsed = 1'b0;

  // Transaction-level model: who owns the L2 port, who was served last, grants per port
  int own = 0;      // 0 none, 1 I-cache, 2 D-cache
  int last = 1;
  int mcnt_i = 0, mcnt_d = 0;

  function automatic int pick_next();
    logic ireq, dreq;
    ireq = i_read | i_write;
    dreq = d_read | d_write;
    if (own == 0) begin
      if (ireq && dreq) return 3 - last;
      else if (dreq) return 2;
      else if (ireq) return 1;
      else return 0;
    end else if (l2_resp) begin
      if (own == 1) return dreq ? 2 : 0;
      else return ireq ? 1 : 0;
    end else begin
      return own;
    end
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own <= 0; last <= 1; mcnt_i <= 0; mcnt_d <= 0;
    end else begin
      own <= pick_next();
      if (own != 0 && l2_resp) last <= own;
      if (pick_next() == 1 && own != 1 && mcnt_i < CMAX) mcnt_i <= mcnt_i + 1;
      if (pick_next() == 2 && own != 2 && mcnt_d < CMAX) mcnt_d <= mcnt_d + 1;
    end
  end

  // I-cache requester: holds strobes until its response, then starts the next entry
  initial begin
    i_read = 1'b0; i_write = 1'b0; i_address = 16'h0000; i_wdata = 128'h0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n && flush) begin
        i_read = 1'b0; i_write = 1'b0; i_act = 1'b0; i_idx = n_i;
      end else begin
        if (i_act && i_got) begin i_read = 1'b0; i_write = 1'b0; i_act = 1'b0; end
        if (!i_act && i_idx < n_i) begin
          i_read = i_tab[i_idx].rd; i_write = i_tab[i_idx].wr;
          i_address = i_tab[i_idx].addr; i_wdata = i_tab[i_idx].wdata;
          i_idx = i_idx + 1; i_act = 1'b1;
        end
      end
    end
  end

  initial begin
    d_read = 1'b0; d_write = 1'b0; d_address = 16'h0000; d_wdata = 128'h0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n && flush) begin
        d_read = 1'b0; d_write = 1'b0; d_act = 1'b0; d_idx = n_d;
      end else begin
        if (d_act && d_got) begin d_read = 1'b0; d_write = 1'b0; d_act = 1'b0; end
        if (!d_act && d_idx < n_d) begin
          d_read = d_tab[d_idx].rd; d_write = d_tab[d_idx].wr;
          d_address = d_tab[d_idx].addr; d_wdata = d_tab[d_idx].wdata;
          d_idx = d_idx + 1; d_act = 1'b1;
        end
      end
    end
  end

  initial forever begin @(negedge clk); i_got = i_resp; end
  initial forever begin @(negedge clk); d_got = d_resp; end

  // L2 responder: one-cycle l2_resp after the request has been visible for lat cycles
  initial begin
    l2_resp = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        l2_resp = 1'b0; rcnt = 0;
      end else begin
        if (l2_resp) begin l2_resp = 1'b0; rcnt = 0; end
        if (l2_read | l2_write) begin
          rcnt = rcnt + 1;
          if (rcnt >= lat) l2_resp = 1'b1;
        end else begin
          rcnt = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [127:0] e_lr, e_lw, e_la, e_lwd;
    e_lr  = (own == 1) ? 128'(i_read)    : (own == 2) ? 128'(d_read)    : 128'h0;
    e_lw  = (own == 1) ? 128'(i_write)   : (own == 2) ? 128'(d_write)   : 128'h0;
    e_la  = (own == 1) ? 128'(i_address) : (own == 2) ? 128'(d_address) : 128'h0;
    e_lwd = (own == 1) ? i_wdata         : (own == 2) ? d_wdata         : 128'h0;
    chk("l2_read", 128'(l2_read), e_lr);
    chk("l2_write", 128'(l2_write), e_lw);
    chk("l2_address", 128'(l2_address), e_la);
    chk("l2_wdata", l2_wdata, e_lwd);
    chk("i_resp", 128'(i_resp), 128'((own == 1) && l2_resp));
    chk("d_resp", 128'(d_resp), 128'((own == 2) && l2_resp));
    chk("i_rdata", i_rdata, (own == 1) ? l2_rdata : 128'h0);
    chk("d_rdata", d_rdata, (own == 2) ? l2_rdata : 128'h0);
    chk("i_grant_cnt", 128'(i_grant_cnt), 128'(mcnt_i));
    chk("d_grant_cnt", 128'(d_grant_cnt), 128'(mcnt_d));
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    if (i_resp) i_pulsed = 1'b1;
    if ((i_resp || d_resp) && n_log < 16) begin
      resp_log[n_log] = i_resp ? 1 : 2;
      n_log = n_log + 1;
    end
  endtask

  task automatic push_i(input logic rd, input logic wr, input logic [15:0] a, input logic [127:0] w);
    i_tab[n_i] = '{rd, wr, a, w};
    n_i = n_i + 1;
  endtask

  task automatic push_d(input logic rd, input logic wr, input logic [15:0] a, input logic [127:0] w);
    d_tab[n_d] = '{rd, wr, a, w};
    n_d = n_d + 1;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (!(i_idx == n_i && !i_act && d_idx == n_d && !d_act && !l2_read && !l2_write) && g < 600) begin
      tick();
      g = g + 1;
    end
    chk(tag, 128'(g < 600), 128'h1);
  endtask

  task automatic do_reset();
    flush = 1'b1;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    flush = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pat_a5, pat_0f;
    int k;
    pat_a5 = {16{8'hA5}};
    pat_0f = {16{8'h0F}};
    reset_n = 1'b0;
    l2_rdata = {8{16'h1234}};

    // Power-on reset with both requests held: outputs quiet, then D wins the first tie
    lat = 2;
    push_i(1'b1, 1'b0, 16'h0100, 128'h0);
    push_d(1'b1, 1'b0, 16'h0200, 128'h0);
    tick(); tick(); tick();
    chk("rst_req_held", 128'(i_read & d_read), 128'h1);
    chk("rst_l2_read", 128'(l2_read), 128'h0);
    chk("rst_cnts", 128'({i_grant_cnt, d_grant_cnt}), 128'h0);
    reset_n = 1'b1;
    tick();
    chk("first_grant_addr", 128'(l2_address), 128'h0200);
    chk("first_grant_dcnt", 128'(d_grant_cnt), 128'h1);
    wait_idle("rst_done");

    // Single I read, L2 answers 3 cycles after grant
    do_reset();
    lat = 3;
    l2_rdata = pat_a5;
    push_i(1'b1, 1'b0, 16'h1230, 128'h0);
    tick();
    chk("single_not_yet", 128'(l2_read), 128'h0);
    tick();
    chk("single_l2_read", 128'(l2_read), 128'h1);
    chk("single_addr", 128'(l2_address), 128'h1230);
    k = 0;
    while (!i_resp && k < 20) begin tick(); k = k + 1; end
    chk("single_resp_lat", 128'(k), 128'h2);
    chk("single_rdata", i_rdata, pat_a5);
    chk("single_d_resp", 128'(d_resp), 128'h0);
    tick();
    chk("single_idle", 128'({l2_read, l2_write}), 128'h0);
    chk("single_icnt", 128'(i_grant_cnt), 128'h1);
    wait_idle("single_done");

    // Simultaneous: D write served first, then handoff to I without bubble
    do_reset();
    lat = 2;
    l2_rdata = {4{32'hDEADBEEF}};
    push_i(1'b1, 1'b0, 16'h0040, 128'h0);
    push_d(1'b0, 1'b1, 16'h8000, pat_0f);
    tick(); tick();
    chk("sim_l2_write", 128'({l2_read, l2_write}), 128'h1);
    chk("sim_addr_d", 128'(l2_address), 128'h8000);
    chk("sim_wdata", l2_wdata, pat_0f);
    k = 0;
    while (!d_resp && k < 20) begin tick(); k = k + 1; end
    chk("sim_d_resp_seen", 128'(k < 20), 128'h1);
    tick();
    chk("sim_handoff_read", 128'({l2_read, l2_write}), 128'h2);
    chk("sim_handoff_addr", 128'(l2_address), 128'h0040);
    wait_idle("sim_done");
    chk("sim_cnts", 128'({i_grant_cnt, d_grant_cnt}), 128'h11);

    // Fairness: three transactions queued on each port
    do_reset();
    lat = 2;
    n_log = 0;
    for (int t = 0; t < 3; t++) begin
      push_i(1'b1, 1'b0, 16'(16'h0A00 + t), 128'h0);
      push_d(1'b1, 1'b0, 16'(16'h0B00 + t), 128'h0);
    end
    wait_idle("fair_done");
    chk("fair_nlog", 128'(n_log), 128'h6);
    for (int t = 0; t < 6; t++) chk("fair_order", 128'(resp_log[t]), (t % 2 == 0) ? 128'h2 : 128'h1);
    chk("fair_cnts", 128'({i_grant_cnt, d_grant_cnt}), 128'h33);

    // Asynchronous reset in the middle of an I grant
    do_reset();
    lat = 10;
    i_pulsed = 1'b0;
    push_i(1'b1, 1'b0, 16'h3000, 128'h0);
    k = 0;
    while (!l2_read && k < 10) begin tick(); k = k + 1; end
    chk("mid_granted", 128'(l2_read), 128'h1);
    flush = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_l2_read_drop", 128'(l2_read), 128'h0);
    chk("mid_addr_drop", 128'(l2_address), 128'h0);
    tick(); tick();
    reset_n = 1'b1;
    flush = 1'b0;
    tick(); tick(); tick();
    chk("mid_idle", 128'({l2_read, l2_write}), 128'h0);
    chk("mid_no_resp", 128'(i_pulsed), 128'h0);

    // Saturation: 20 D-only transactions against a 4-bit counter
    do_reset();
    lat = 1;
    for (int t = 0; t < 20; t++) push_d(t[0], ~t[0], 16'(16'h4000 + t), 128'(t));
    wait_idle("sat_done");
    chk("sat_dcnt", 128'(d_grant_cnt), 128'hF);
    chk("sat_icnt", 128'(i_grant_cnt), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
